ex_mem_skid: RTL and testbench
==============================

Name: ex_mem_skid

Overview:
- Execute-to-memory pipeline boundary, directly downstream of the 64-bit ALU.
- Captures the ALU result, zero flag, store data, destination register and memory/writeback control each cycle.
- Presents the captured bundle to the memory stage through a valid/ready handshake.
- A two-entry skid buffer absorbs one cycle of memory-stage backpressure, so in_ready is a registered signal and never combinationally depends on out_ready.

Parameters:
- N, 64, datapath width of result, store data and branch target.
- REG_W, 5, destination register index width (X0..X31).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous kill of all buffered entries (branch taken / exception).
- in_valid  input  1  execute stage presents a bundle.
- in_ready  output  1  block can accept a bundle this cycle.
- in_result  input  N  ALU result.
- in_zero  input  1  ALU zero flag.
- in_wdata  input  N  store data (operand b before the ALU mux).
- in_btarget  input  N  computed branch target.
- in_rd  input  REG_W  destination register.
- in_ctrl  input  5  {reg_write, mem_to_reg, mem_read, mem_write, branch}.
- out_valid  output  1  bundle presented to memory stage.
- out_ready  input  1  memory stage accepts.
- out_result, out_zero, out_wdata, out_btarget, out_rd, out_ctrl  output  same widths  registered payload.

Behaviour:
- Clock and reset:
  - clk is the only clock. reset is asynchronous and active-high.
  - While reset is high, all storage clears immediately: out_valid=0, all out_* payload=0, skid entry invalid and zero, state EMPTY.
  - in_ready=1 from the cycle reset deasserts.
- Storage: main register (drives out_*) and skid register.
- States:
  - EMPTY: main invalid.
  - ONE: main valid, skid empty.
  - FULL: main and skid valid.
- in_ready = (state != FULL), registered, no combinational path from out_ready.
- Acceptance is in_valid && in_ready. Delivery is out_valid && out_ready.
- EMPTY:
  - Accept: main <= input, next ONE.
  - Otherwise stay EMPTY.
  - Latency input-to-output is 1 cycle.
- ONE:
  - Accept and deliver: main <= input, stay ONE (full throughput).
  - Deliver only: next EMPTY.
  - Accept only: skid <= input, next FULL.
  - Neither: hold.
- FULL:
  - Deliver: main <= skid, next ONE.
  - No accept is possible in FULL.
  - Otherwise hold.
- Ordering is strictly FIFO; no bundle is dropped or duplicated.
- Payload stability: main payload does not change while out_valid=1 and out_ready=0.
- flush:
  - Next edge, state EMPTY and out_valid=0, regardless of in_valid or out_ready in the same cycle.
  - A bundle offered in the flush cycle is discarded.
  - Payload registers keep their values; only the valid bits clear.
- in_ctrl of a discarded or invalid bundle has no effect downstream; downstream qualifies on out_valid only.
- Reset asserted mid-transfer: immediate clear as above, and the in-flight bundle is lost.
- Widths: payload passes unmodified. No arithmetic in this block except the optional counters.

Optional Feature:
- Macro: EX_MEM_PERF_EN.
- When defined, two extra outputs:
  - perf_xfers [31:0]: count of deliveries.
  - perf_stalls [31:0]: cycles with out_valid=1 and out_ready=0.
- Both counters saturate at 32'hFFFF_FFFF, clear on reset, and are unaffected by flush.
- When undefined, the ports and logic are absent; core behaviour is identical.

Decomposition:
- Shared package ex_mem_pkg:
  - typedef ex_ctrl_t, packed struct {reg_write, mem_to_reg, mem_read, mem_write, branch}.
  - typedef ex_mem_bundle_t, packed {result, zero, wdata, btarget, rd, ctrl}.
  - enum skid_state_t {EMPTY, ONE, FULL}.
  - Constants N=64, REG_W=5.
- One natural sub-module: skid_buffer, a generic two-entry valid/ready buffer parameterised on payload type.
- ex_mem_skid instantiates skid_buffer with ex_mem_bundle_t and adds flush and perf logic.

Test Plan:
- Reset then in_valid=1, result=64'h0000_0000_0000_002A, rd=5'd3, ctrl=5'b10000, out_ready=1 -> next cycle out_valid=1, out_result=64'h2A, out_rd=3; out_zero matches input.
- Streaming: 8 back-to-back bundles, results 1..8, out_ready=1 -> outputs 1..8 on 8 consecutive cycles, in_ready constantly 1.
- Backpressure: send A=64'hA, B=64'hB with out_ready=0 -> state FULL, in_ready=0, out_result=A stable. Raise out_ready -> A, then B, on consecutive cycles, then out_valid=0.
- Flush in FULL state with in_valid=1 (C=64'hC) -> next cycle out_valid=0, in_ready=1; C never appears.
- Async reset asserted mid-clock while FULL -> out_valid=0 and out_result=0 before the next edge.
- With EX_MEM_PERF_EN: 3 deliveries plus 4 stall cycles -> perf_xfers=3, perf_stalls=4. Preload near max and stall further -> perf_stalls saturates at 32'hFFFF_FFFF.

Source files
------------

// File: rtl/ex_mem_pkg.sv
// ex_mem_pkg: shared types and constants for the execute-to-memory boundary.
// Holds the control/payload bundle layout, the skid buffer state encoding and
// a saturating-increment helper used by the optional performance counters.
package ex_mem_pkg;

    localparam int N      = 64;
    localparam int REG_W  = 5;
    localparam int CTRL_W = 5;

    // Memory/writeback control, MSB first: {reg_write, mem_to_reg, mem_read, mem_write, branch}
    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
        logic mem_read;
        logic mem_write;
        logic branch;
    } ex_ctrl_t;

    // Everything the memory stage needs from execute, moved as one word
    typedef struct packed {
        logic [N-1:0]     result;
        logic             zero;
        logic [N-1:0]     wdata;
        logic [N-1:0]     btarget;
        logic [REG_W-1:0] rd;
        ex_ctrl_t         ctrl;
    } ex_mem_bundle_t;

    // Occupancy of the two-entry buffer
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        logic [31:0] result;
        if (value == 32'hFFFF_FFFF) begin
            result = value;
        end else begin
            result = value + 32'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/skid_buffer.sv
// skid_buffer: generic two-entry valid/ready buffer, payload type T.
// The main entry drives the outputs; the skid entry catches the one bundle
// that may arrive while the consumer stalls, which lets in_ready come straight
// from a flop with no combinational path from out_ready.
// flush drops both entries but leaves the payload flops untouched.
module skid_buffer
    import ex_mem_pkg::*;
#(
    parameter type T = logic [7:0]
)
(
    input  logic clk,
    input  logic rst,
    input  logic flush,
    input  logic in_valid,
    output logic in_ready,
    input  T     in_data,
    output logic out_valid,
    input  logic out_ready,
    output T     out_data
);

    skid_state_t r_state;
    logic        r_in_ready;
    logic        r_out_valid;
    T            r_main;
    T            r_skid;

    logic        w_accept;
    logic        w_deliver;

    assign w_accept  = in_valid & r_in_ready;
    assign w_deliver = r_out_valid & out_ready;

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_main;

    // Occupancy FSM: moves bundles input -> main/skid -> output in FIFO order
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_main      <= '0;
            r_skid      <= '0;
        end else if (flush) begin
            // Kill everything in flight; the offered bundle is ignored too
            r_state     <= EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        r_main      <= in_data;
                        r_out_valid <= 1'b1;
                        r_state     <= ONE;
                    end else begin
                        r_state     <= EMPTY;
                    end
                    r_in_ready <= 1'b1;
                end
                ONE: begin
                    if (w_accept && w_deliver) begin
                        // Full throughput: replace the departing bundle
                        r_main     <= in_data;
                        r_state    <= ONE;
                        r_in_ready <= 1'b1;
                    end else if (w_deliver) begin
                        r_out_valid <= 1'b0;
                        r_state     <= EMPTY;
                        r_in_ready  <= 1'b1;
                    end else if (w_accept) begin
                        // Consumer stalled: park the newcomer and close the input
                        r_skid     <= in_data;
                        r_state    <= FULL;
                        r_in_ready <= 1'b0;
                    end else begin
                        r_state    <= ONE;
                        r_in_ready <= 1'b1;
                    end
                end
                FULL: begin
                    if (w_deliver) begin
                        r_main     <= r_skid;
                        r_state    <= ONE;
                        r_in_ready <= 1'b1;
                    end else begin
                        r_state    <= FULL;
                        r_in_ready <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= EMPTY;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/ex_mem_skid.sv
// ex_mem_skid: execute-to-memory pipeline register with a two-entry skid
// buffer. Packs the ALU outputs into one bundle, buffers it, and unpacks it
// toward the memory stage. Downstream must qualify everything on out_valid.
// Optional: define EX_MEM_PERF_EN to add saturating delivery and stall
// counters (perf_xfers, perf_stalls); flush does not touch them.
module ex_mem_skid
    import ex_mem_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N-1:0]      in_result,
    input  logic              in_zero,
    input  logic [N-1:0]      in_wdata,
    input  logic [N-1:0]      in_btarget,
    input  logic [REG_W-1:0]  in_rd,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N-1:0]      out_result,
    output logic              out_zero,
    output logic [N-1:0]      out_wdata,
    output logic [N-1:0]      out_btarget,
    output logic [REG_W-1:0]  out_rd,
    output logic [CTRL_W-1:0] out_ctrl
`ifdef EX_MEM_PERF_EN
    ,
    output logic [31:0]       perf_xfers,
    output logic [31:0]       perf_stalls
`endif
);

    ex_mem_bundle_t w_in_bundle;
    ex_mem_bundle_t w_out_bundle;
    logic           w_out_valid;

    assign w_in_bundle = {in_result, in_zero, in_wdata, in_btarget, in_rd, in_ctrl};

    skid_buffer #(
        .T (ex_mem_bundle_t)
    ) u_skid (
        .clk       (clk),
        .rst       (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (w_in_bundle),
        .out_valid (w_out_valid),
        .out_ready (out_ready),
        .out_data  (w_out_bundle)
    );

    assign out_valid   = w_out_valid;
    assign out_result  = w_out_bundle.result;
    assign out_zero    = w_out_bundle.zero;
    assign out_wdata   = w_out_bundle.wdata;
    assign out_btarget = w_out_bundle.btarget;
    assign out_rd      = w_out_bundle.rd;
    assign out_ctrl    = w_out_bundle.ctrl;

`ifdef EX_MEM_PERF_EN
    logic [31:0] r_perf_xfers;
    logic [31:0] r_perf_stalls;
    logic        w_deliver;
    logic        w_stall;

    assign w_deliver = w_out_valid & out_ready;
    assign w_stall   = w_out_valid & ~out_ready;

    // Saturating counters of deliveries and stalled cycles; only reset clears them
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_perf_xfers  <= 32'd0;
            r_perf_stalls <= 32'd0;
        end else begin
            if (w_deliver) begin
                r_perf_xfers <= sat_inc32(r_perf_xfers);
            end else begin
                r_perf_xfers <= r_perf_xfers;
            end
            if (w_stall) begin
                r_perf_stalls <= sat_inc32(r_perf_stalls);
            end else begin
                r_perf_stalls <= r_perf_stalls;
            end
        end
    end

    assign perf_xfers  = r_perf_xfers;
    assign perf_stalls = r_perf_stalls;
`else
    // Counters not built: the core path above is the whole block.
`endif

endmodule

// File: tb/tb_ex_mem_skid.sv
// tb_ex_mem_skid: directed and randomized checks of ex_mem_skid against a
// queue-based model (a FIFO of at most two bundles).
module tb_ex_mem_skid;

    localparam int BW = 203;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_result;
    logic        in_zero;
    logic [63:0] in_wdata;
    logic [63:0] in_btarget;
    logic [4:0]  in_rd;
    logic [4:0]  in_ctrl;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_result;
    logic        out_zero;
    logic [63:0] out_wdata;
    logic [63:0] out_btarget;
    logic [4:0]  out_rd;
    logic [4:0]  out_ctrl;
`ifdef EX_MEM_PERF_EN
    logic [31:0] perf_xfers;
    logic [31:0] perf_stalls;
    logic [31:0] m_xfers;
    logic [31:0] m_stalls;
`endif

    int total = 0;
    int bad   = 0;
    logic [BW-1:0] q[$];

    ex_mem_skid dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_result   (in_result),
        .in_zero     (in_zero),
        .in_wdata    (in_wdata),
        .in_btarget  (in_btarget),
        .in_rd       (in_rd),
        .in_ctrl     (in_ctrl),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_zero    (out_zero),
        .out_wdata   (out_wdata),
        .out_btarget (out_btarget),
        .out_rd      (out_rd),
        .out_ctrl    (out_ctrl)
`ifdef EX_MEM_PERF_EN
        ,
        .perf_xfers  (perf_xfers),
        .perf_stalls (perf_stalls)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [BW-1:0] cur_in();
        return {in_result, in_zero, in_wdata, in_btarget, in_rd, in_ctrl};
    endfunction

    function automatic logic [BW-1:0] cur_out();
        return {out_result, out_zero, out_wdata, out_btarget, out_rd, out_ctrl};
    endfunction

    task automatic model_reset();
        q.delete();
`ifdef EX_MEM_PERF_EN
        m_xfers  = 32'd0;
        m_stalls = 32'd0;
`endif
    endtask

    // Apply one clock edge to the model using the inputs currently driven
    task automatic model_update();
        bit acc;
        bit dlv;
        acc = in_valid && (q.size() < 2);
        dlv = (q.size() > 0) && out_ready;
`ifdef EX_MEM_PERF_EN
        if (dlv && m_xfers != 32'hFFFF_FFFF) m_xfers = m_xfers + 32'd1;
        if ((q.size() > 0) && !out_ready && m_stalls != 32'hFFFF_FFFF) m_stalls = m_stalls + 32'd1;
`endif
        if (flush) begin
            q.delete();
        end else begin
            if (dlv) void'(q.pop_front());
            if (acc) q.push_back(cur_in());
        end
    endtask

    task automatic compare_all();
        check("in_ready", BW'(in_ready), BW'(q.size() < 2));
        check("out_valid", BW'(out_valid), BW'(q.size() > 0));
        if (q.size() > 0) check("payload", cur_out(), q[0]);
`ifdef EX_MEM_PERF_EN
        check("perf_xfers", BW'(perf_xfers), BW'(m_xfers));
        check("perf_stalls", BW'(perf_stalls), BW'(m_stalls));
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare_all();
    endtask

    task automatic drive(input logic v, input logic [63:0] res, input logic z,
                         input logic [4:0] rd, input logic [4:0] ctrl);
        in_valid   = v;
        in_result  = res;
        in_zero    = z;
        in_wdata   = ~res;
        in_btarget = res + 64'h1000;
        in_rd      = rd;
        in_ctrl    = ctrl;
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 64'h0, 1'b0, 5'd0, 5'd0);
        model_reset();
        #12;
        check("rst_out_valid", BW'(out_valid), BW'(1'b0));
        check("rst_out_result", BW'(out_result), BW'(64'h0));
        check("rst_out_rd", BW'(out_rd), BW'(5'd0));
        reset = 1'b0;
        @(negedge clk);
        check("rst_in_ready", BW'(in_ready), BW'(1'b1));

        // Single bundle, one-cycle latency
        out_ready = 1'b1;
        drive(1'b1, 64'h0000_0000_0000_002A, 1'b1, 5'd3, 5'b10000);
        tick();
        check("t1_valid", BW'(out_valid), BW'(1'b1));
        check("t1_result", BW'(out_result), BW'(64'h2A));
        check("t1_rd", BW'(out_rd), BW'(5'd3));
        check("t1_zero", BW'(out_zero), BW'(1'b1));
        check("t1_ctrl", BW'(out_ctrl), BW'(5'b10000));
        drive(1'b0, 64'h0, 1'b0, 5'd0, 5'd0);
        tick();
        check("t1_drained", BW'(out_valid), BW'(1'b0));

        // Streaming 1..8 at full rate
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 64'(i), 1'b0, 5'(i), 5'b10000);
            tick();
            check("stream_result", BW'(out_result), BW'(64'(i)));
            check("stream_in_ready", BW'(in_ready), BW'(1'b1));
        end
        drive(1'b0, 64'h0, 1'b0, 5'd0, 5'd0);
        tick();

        // Backpressure: A then B into a stalled consumer
        out_ready = 1'b0;
        drive(1'b1, 64'hA, 1'b0, 5'd1, 5'b00100);
        tick();
        drive(1'b1, 64'hB, 1'b0, 5'd2, 5'b00010);
        tick();
        check("bp_in_ready_full", BW'(in_ready), BW'(1'b0));
        check("bp_hold_a", BW'(out_result), BW'(64'hA));
        drive(1'b0, 64'h0, 1'b0, 5'd0, 5'd0);
        tick();
        check("bp_stable_a", BW'(out_result), BW'(64'hA));
        out_ready = 1'b1;
        tick();
        check("bp_then_b", BW'(out_result), BW'(64'hB));
        check("bp_b_valid", BW'(out_valid), BW'(1'b1));
        tick();
        check("bp_empty", BW'(out_valid), BW'(1'b0));

        // Flush while FULL with C offered
        out_ready = 1'b0;
        drive(1'b1, 64'hD, 1'b0, 5'd4, 5'b11000);
        tick();
        drive(1'b1, 64'hE, 1'b0, 5'd5, 5'b11000);
        tick();
        flush = 1'b1;
        drive(1'b1, 64'hC, 1'b0, 5'd6, 5'b10000);
        tick();
        flush = 1'b0;
        check("fl_valid", BW'(out_valid), BW'(1'b0));
        check("fl_in_ready", BW'(in_ready), BW'(1'b1));
        check("fl_payload_kept", BW'(out_result), BW'(64'hD));
        drive(1'b0, 64'h0, 1'b0, 5'd0, 5'd0);
        out_ready = 1'b1;
        tick();
        tick();
        check("fl_no_c", BW'(out_valid), BW'(1'b0));

        // Asynchronous reset mid-cycle while FULL
        out_ready = 1'b0;
        drive(1'b1, 64'h11, 1'b0, 5'd7, 5'b10000);
        tick();
        drive(1'b1, 64'h22, 1'b0, 5'd8, 5'b10000);
        tick();
        drive(1'b0, 64'h0, 1'b0, 5'd0, 5'd0);
        #2 reset = 1'b1;
        #1;
        check("ar_valid", BW'(out_valid), BW'(1'b0));
        check("ar_result", BW'(out_result), BW'(64'h0));
        #1 reset = 1'b0;
        model_reset();
        tick();
        check("ar_in_ready", BW'(in_ready), BW'(1'b1));

        // Randomized traffic with occasional flush
        for (int n = 0; n < 3000; n++) begin
            drive(($urandom_range(0, 3) != 0), {$urandom, $urandom}, 1'($urandom),
                  5'($urandom), 5'($urandom));
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            tick();
        end
        flush = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
